// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execution-side ALU with valid/ready on both sides.
// Logic, arithmetic and compare ops complete one cycle after accept.
// Shifts use an iterative 1-bit-per-cycle shifter by default.
// Define ALU_FAST_SHIFT_EN to replace it with a single-cycle barrel shifter.
// In that build the SHIFT state is never entered. The port list is the same in both builds.
module alu_seq_exec #(
   parameter  int DATA_WIDTH = 32,
   localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  IllegalOp
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_EQ  = 4'b1000;
   localparam logic [3:0] OP_XOR = 4'b1001;
   localparam logic [3:0] OP_SLT = 4'b1100;

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   res_q,   res_d;
   logic                    zero_q,  zero_d;
   logic                    ill_q,   ill_d;
   logic [SHAMT_W-1:0]      cnt_q,   cnt_d;
   logic [3:0]              op_q,    op_d;

   logic [SHAMT_W-1:0]      shamt;

   assign shamt = SrcB[SHAMT_W-1:0];

   function automatic logic op_is_legal(input logic [3:0] op);
      logic legal;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL,
         OP_SRL, OP_SRA, OP_EQ, OP_XOR, OP_SLT: legal = 1'b1;
         default:                               legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic op_is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Single-cycle result for every legal op.
   // In the iterative build a shift arriving here has a zero amount, so its result is the source.
   function automatic logic [DATA_WIDTH-1:0] alu_calc(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [SHAMT_W-1:0]    sh
   );
      logic [DATA_WIDTH-1:0] r;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_EQ:  r = (a == b) ? ONE : '0;
         OP_SLT: r = ($signed(a) < $signed(b)) ? ONE : '0;
`ifdef ALU_FAST_SHIFT_EN
         OP_SLL: r = a << sh;
         OP_SRL: r = a >> sh;
         OP_SRA: r = DATA_WIDTH'($signed(a) >>> sh);
`else
         OP_SLL, OP_SRL, OP_SRA: r = (sh == '0) ? a : a;
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   // One step of the iterative shifter; SRA replicates the sign bit.
   function automatic logic [DATA_WIDTH-1:0] shift_one(
      input logic [3:0]            op,
      input logic [DATA_WIDTH-1:0] v
   );
      logic [DATA_WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, v[DATA_WIDTH-1:1]};
         OP_SRA:  r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Next-state, datapath and flag computation.
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d  = Operation;
               ill_d = !op_is_legal(Operation);
               res_d = op_is_legal(Operation) ? alu_calc(Operation, SrcA, SrcB, shamt) : '0;
               state_d = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
               if (op_is_shift(Operation) && (shamt != '0)) begin
                  res_d   = SrcA;
                  cnt_d   = shamt;
                  state_d = ST_SHIFT;
               end
`endif
            end
         end
         ST_SHIFT: begin
            res_d = shift_one(op_q, res_q);
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Zero always tracks the result register, so it is stable whenever the result is.
      zero_d = (res_d == '0);
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign ALUResult = res_q;
   assign Zero      = zero_q;
   assign IllegalOp = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model of the operation table.
module tb_alu_seq_exec;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        IllegalOp;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq_exec #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero),
      .IllegalOp (IllegalOp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: result, illegal flag and latency from the operation table.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      int sh;
      sh  = int'(b[4:0]);
      ill = 1'b0;
      lat = 1;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0011: r = a - b;
         4'b1001: r = a ^ b;
         4'b1000: r = (a == b) ? 32'd1 : 32'd0;
         4'b1100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0100: r = a << sh;
         4'b0101: r = a >> sh;
         4'b0111: r = $signed(a) >>> sh;
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
`ifndef ALU_FAST_SHIFT_EN
      if (op == 4'b0100 || op == 4'b0101 || op == 4'b0111) lat = 1 + sh;
`endif
   endfunction

   // Issue one op, hold out_ready low for bp cycles after the result appears, then release.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int bp);
      logic [31:0] er;
      logic        eill;
      int          elat;
      int          lat;
      model(op, a, b, er, eill, elat);
      @(negedge clk);
      check_val({tag, ".in_ready"}, in_ready, 1);
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      SrcA = $urandom; SrcB = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, ".latency"}, lat, elat);
      check_val({tag, ".result"}, ALUResult, er);
      check_val({tag, ".zero"}, Zero, (er == 32'd0));
      check_val({tag, ".illegal"}, IllegalOp, eill);
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1; Operation = 4'(op + 4'd1); SrcA = $urandom; SrcB = $urandom;
         @(negedge clk);
         check_val({tag, ".bp_valid"}, out_valid, 1);
         check_val({tag, ".bp_ready"}, in_ready, 0);
         check_val({tag, ".bp_result"}, ALUResult, er);
         check_val({tag, ".bp_zero"}, Zero, (er == 32'd0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val({tag, ".rel_valid"}, out_valid, 0);
      check_val({tag, ".rel_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
      repeat (3) @(negedge clk);
      check_val("rst.in_ready", in_ready, 1);
      check_val("rst.out_valid", out_valid, 0);
      check_val("rst.result", ALUResult, 0);
      check_val("rst.zero", Zero, 1);
      check_val("rst.illegal", IllegalOp, 0);
      rst_n = 1'b1;

      run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("sub", 4'b0011, 32'd5, 32'd7, 0);
      run_op("and", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 0);
      run_op("or", 4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 0);
      run_op("xor", 4'b1001, 32'h0000_F0F0, 32'h0000_0FF0, 0);
      run_op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 0);
      run_op("sll0", 4'b0100, 32'h1234_5678, 32'd0, 0);
      run_op("slt", 4'b1100, 32'hFFFF_FFFF, 32'd1, 0);
      run_op("eq", 4'b1000, 32'd7, 32'd7, 0);
      run_op("illegal", 4'b0110, 32'hDEAD_BEEF, 32'd3, 0);
      run_op("bp5", 4'b0010, 32'h0000_1000, 32'h0000_0234, 5);

      // Asynchronous reset on the third cycle of a 10-bit SRL.
      @(negedge clk);
      Operation = 4'b0101; SrcA = 32'hF000_0000; SrcB = 32'd10; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst.in_ready", in_ready, 1);
      check_val("arst.out_valid", out_valid, 0);
      check_val("arst.result", ALUResult, 0);
      check_val("arst.zero", Zero, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_val("arst.no_valid", seen, 0);
      run_op("after_rst", 4'b0101, 32'hF000_0000, 32'd10, 0);

      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         run_op($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
